// File: rtl/uart_status_tx.sv
// Status/response transmitter: on an accepted request, sends the 5-byte 8N1 frame
// A5, cmd, data_hi, data_lo, checksum on a UART TX line, LSB first, with no gap between bytes.
module uart_status_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [7:0]  cmd_i,
  input  logic [15:0] data_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        drop_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W       = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [7:0]        HEADER    = 8'hA5;
  localparam logic [2:0]        LAST_BIT  = 3'd7;
  localparam logic [2:0]        LAST_BYTE = 3'd4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_status_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  logic [1:0]        state_q,    state_d;
  logic [BAUD_W-1:0] baud_q,     baud_d;
  logic [2:0]        bit_idx_q,  bit_idx_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        shift_q,    shift_d;
  logic [7:0]        cmd_q,      cmd_d;
  logic [15:0]       data_q,     data_d;
  logic [7:0]        csum_q,     csum_d;
  logic              tx_q,       tx_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              drop_q,     drop_d;

  logic              baud_end;
  logic [7:0]        next_byte;

  assign baud_end = (baud_q == BAUD_LAST);

  // Byte that follows the one currently indexed; only consulted when leaving STOP.
  always_comb begin
    next_byte = csum_q;
    case (byte_idx_q)
      3'd0:    next_byte = cmd_q;
      3'd1:    next_byte = data_q[15:8];
      3'd2:    next_byte = data_q[7:0];
      default: next_byte = csum_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    csum_d     = csum_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drop_d     = req_i & busy_q;

    case (state_q)
      S_IDLE: begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        baud_d     = '0;
        bit_idx_d  = '0;
        byte_idx_d = '0;
        if (req_i) begin
          cmd_d   = cmd_i;
          data_d  = data_i;
          csum_d  = cmd_i ^ data_i[15:8] ^ data_i[7:0];
          shift_d = HEADER;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_idx_q < LAST_BYTE) begin
            // Next start bit goes out immediately: bytes are back-to-back.
            byte_idx_d = byte_idx_q + 3'd1;
            shift_d    = next_byte;
            state_d    = S_START;
            tx_d       = 1'b0;
          end else begin
            byte_idx_d = '0;
            state_d    = S_IDLE;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      csum_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      csum_q     <= csum_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  assign uart_tx_o = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign drop_o    = drop_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: a frame-level reference model predicts the line level and
// strobes every cycle, and a mid-bit UART decoder checks the bytes of directed frames.
module tb_uart_status_tx;

  localparam int CPB          = 10;
  localparam int FRAME_BITS   = 50;
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;

  logic        clk;
  logic        rst;
  logic        reqI;
  logic [7:0]  cmdI;
  logic [15:0] dataI;
  logic        uart_tx_o;
  logic        busy_o;
  logic        done_o;
  logic        drop_o;

  int checkCount = 0;
  int failCount  = 0;
  bit checkEn    = 0;

  uart_status_tx #(
    .CLK_FREQ (1000),
    .BAUD_RATE(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (reqI),
    .cmd_i    (cmdI),
    .data_i   (dataI),
    .uart_tx_o(uart_tx_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .drop_o   (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame content straight from the byte layout: A5, cmd, hi, lo, xor of the three.
  function automatic logic [39:0] expFrame(input logic [7:0] c, input logic [15:0] d);
    logic [7:0] x;
    x = c ^ d[15:8] ^ d[7:0];
    return {8'hA5, c, d[15:8], d[7:0], x};
  endfunction

  // Reference model: the frame is a list of 50 line levels, each held CPB cycles.
  logic mBits [FRAME_BITS];
  bit   mBusy;
  int   mPos;
  logic expTx, expBusy, expDone, expDrop;

  task automatic buildFrame(input logic [7:0] c, input logic [15:0] d);
    logic [39:0] f;
    logic [7:0]  b;
    f = expFrame(c, d);
    for (int k = 0; k < 5; k++) begin
      b = f[39 - 8*k -: 8];
      mBits[k*10] = 1'b0;
      for (int j = 0; j < 8; j++) mBits[k*10 + 1 + j] = b[j];
      mBits[k*10 + 9] = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy = 0; mPos = 0;
      expTx = 1'b1; expBusy = 1'b0; expDone = 1'b0; expDrop = 1'b0;
    end else begin
      expDrop = reqI && mBusy;
      expDone = 1'b0;
      if (mBusy) begin
        mPos++;
        if (mPos == FRAME_CYCLES) begin
          mBusy = 0; expTx = 1'b1; expDone = 1'b1;
        end else begin
          expTx = mBits[mPos / CPB];
        end
      end else if (reqI) begin
        buildFrame(cmdI, dataI);
        mBusy = 1; mPos = 0; expTx = mBits[0];
      end else begin
        expTx = 1'b1;
      end
      expBusy = mBusy;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_uart_tx", uart_tx_o, expTx);
      checkOutput("cyc_busy", busy_o, expBusy);
      checkOutput("cyc_done", done_o, expDone);
      checkOutput("cyc_drop", drop_o, expDrop);
    end
  end

  int busyRun = 0;
  int lastBusyLen = 0;
  always @(negedge clk) begin
    if (busy_o === 1'b1) busyRun++;
    else if (busyRun != 0) begin
      lastBusyLen = busyRun;
      busyRun = 0;
    end
  end

  task automatic applyStimulus(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    reqI = 1'b1; cmdI = c; dataI = d;
    @(negedge clk);
    reqI = 1'b0;
  endtask

  // Samples each of the 50 bit cells 4 cycles after its start, so any gap shifts the sampling.
  task automatic decodeFrame(output logic [39:0] frame);
    int         waitCnt;
    logic [7:0] b;
    logic       s;
    frame = '0;
    waitCnt = 0;
    while (uart_tx_o !== 1'b0 && waitCnt < 2000) begin
      @(negedge clk);
      waitCnt++;
    end
    if (uart_tx_o !== 1'b0) begin
      checkOutput("startTimeout", uart_tx_o, 0);
      return;
    end
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      b = '0;
      for (int j = 0; j < 10; j++) begin
        s = uart_tx_o;
        if (j == 0) checkOutput("startBit", s, 0);
        else if (j == 9) checkOutput("stopBit", s, 1);
        else b[j-1] = s;
        if (!(k == 4 && j == 9)) repeat (CPB) @(negedge clk);
      end
      frame[39 - 8*k -: 8] = b;
    end
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneSeen", done_o, 1);
  endtask

  logic [39:0] frame;
  logic [7:0]  rc;
  logic [15:0] rd;

  initial begin
    rst = 1'b1; reqI = 1'b0; cmdI = '0; dataI = '0;
    #6;
    checkOutput("rst_uart_tx", uart_tx_o, 1);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_drop", drop_o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkEn = 1;

    $display("[TB] basic frame");
    applyStimulus(8'h12, 16'h3456);
    checkOutput("startAfterReq", uart_tx_o, 0);
    decodeFrame(frame);
    checkOutput("basicFrame", frame, 40'hA512345670);
    waitDone();
    @(negedge clk);
    checkOutput("busyLen", lastBusyLen, FRAME_CYCLES);
    checkOutput("doneOneCycle", done_o, 0);
    checkOutput("idleHigh", uart_tx_o, 1);
    repeat (5) @(negedge clk);

    $display("[TB] latch isolation");
    applyStimulus(8'h12, 16'h3456);
    cmdI = 8'hFF; dataI = 16'hFFFF;
    decodeFrame(frame);
    checkOutput("latchFrame", frame, 40'hA512345670);
    waitDone();
    repeat (5) @(negedge clk);

    $display("[TB] busy rejection and done-cycle request");
    applyStimulus(8'h12, 16'h3456);
    fork
      decodeFrame(frame);
      begin
        repeat (99) @(negedge clk);
        reqI = 1'b1; cmdI = 8'h77; dataI = 16'h8888;
        @(negedge clk);
        checkOutput("dropPulse", drop_o, 1);
        reqI = 1'b0;
        @(negedge clk);
        checkOutput("dropOneCycle", drop_o, 0);
      end
    join
    checkOutput("rejectFrame", frame, 40'hA512345670);
    waitDone();
    reqI = 1'b1; cmdI = 8'h00; dataI = 16'h0000;
    @(negedge clk);
    reqI = 1'b0;
    checkOutput("noIdleGap", uart_tx_o, 0);
    decodeFrame(frame);
    checkOutput("zeroFrame", frame, 40'hA500000000);
    waitDone();
    repeat (5) @(negedge clk);

    $display("[TB] async reset mid-frame");
    rc = 8'($urandom); rd = 16'($urandom);
    applyStimulus(rc, rd);
    repeat (250) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstTx", uart_tx_o, 1);
    checkOutput("asyncRstBusy", busy_o, 0);
    checkOutput("asyncRstDone", done_o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    rc = 8'($urandom); rd = 16'($urandom);
    applyStimulus(rc, rd);
    decodeFrame(frame);
    checkOutput("postRstFrame", frame, expFrame(rc, rd));
    waitDone();
    repeat (5) @(negedge clk);

    $display("[TB] request held high");
    @(negedge clk);
    reqI = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      cmdI = 8'($urandom); dataI = 16'($urandom);
      @(negedge clk);
    end
    reqI = 1'b0;
    repeat (600) @(negedge clk);

    $display("[TB] random requests");
    for (int i = 0; i < 3000; i++) begin
      reqI  = ($urandom_range(0, 149) == 0);
      cmdI  = 8'($urandom);
      dataI = 16'($urandom);
      @(negedge clk);
    end
    reqI = 1'b0;
    repeat (600) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
